// File: rtl/imem_boot_loader.sv
// Boot loader: receives a byte-stream program image over valid/ready and writes
// big-endian 32-bit words into instruction memory, then releases the core.
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic [15:0] words_loaded,
  output logic        cpu_run,
  output logic        load_err
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, LAST, DONE, ERR} state_t;

  localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [31:0] word_q, word_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] loaded_q, loaded_d;
  logic        accept;
  logic [15:0] hdr_count;

  assign in_ready     = (state_q == HDR0) || (state_q == HDR1) || (state_q == LOAD);
  assign accept       = in_valid && in_ready;
  assign hdr_count    = {count_q[15:8], in_data};
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = loaded_q;
  assign cpu_run      = (state_q == DONE);
  assign load_err     = (state_q == ERR);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    loaded_d   = loaded_q;
    case (state_q)
      IDLE: if (start) state_d = HDR0;
      HDR0: if (accept) begin
        count_d[15:8] = in_data;
        state_d       = HDR1;
      end
      HDR1: if (accept) begin
        count_d    = hdr_count;
        byte_idx_d = 2'd0;
        word_idx_d = 16'd0;
        if (hdr_count == 16'd0 || {1'b0, hdr_count} > MaxWords) state_d = ERR;
        else                                                    state_d = LOAD;
      end
      LOAD: if (accept) begin
        byte_idx_d = byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0: word_d[31:24] = in_data;
          2'd1: word_d[23:16] = in_data;
          2'd2: word_d[15:8]  = in_data;
          default: begin
            // Fourth byte completes the word; the write is issued from registers next cycle.
            word_d[7:0] = in_data;
            we_d        = 1'b1;
            wdata_d     = {word_q[31:8], in_data};
            addr_d      = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            word_idx_d  = word_idx_q + 16'd1;
            loaded_d    = loaded_q + 16'd1;
            if (word_idx_q == count_q - 16'd1) state_d = LAST;
          end
        endcase
      end
      LAST:    state_d = DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= 16'd0;
      byte_idx_q <= 2'd0;
      word_idx_q <= 16'd0;
      word_q     <= 32'd0;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
      loaded_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      loaded_q   <= loaded_d;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: streams hand-built images and checks
// writes, handshake timing, error handling and reset behaviour.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [15:0] words_loaded;
  logic        cpu_run;
  logic        load_err;

  int nChecks = 0;
  int nPass = 0;
  int writeCount = 0;
  int wideCount = 0;
  int stallCount = 0;
  logic prevWe = 1'b0;
  logic [31:0] logAddr [0:511];
  logic [31:0] logData [0:511];

  imem_boot_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .words_loaded(words_loaded), .cpu_run(cpu_run), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled mid-cycle; back-to-back strobes mean a stretched pulse.
  always @(negedge clk) begin
    if (imem_we) begin
      if (writeCount < 512) begin
        logAddr[writeCount] = imem_addr;
        logData[writeCount] = imem_wdata;
      end
      writeCount++;
      if (prevWe) wideCount++;
    end
    prevWe = imem_we;
  end

  function automatic logic [31:0] wordPattern(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {8'hC0, b, 8'(i * 3), ~b};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic resetDut();
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    writeCount = 0;
    wideCount = 0;
    stallCount = 0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offers one byte after an optional idle gap and returns 1ns after it is consumed.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit taken = 1'b0;
    in_valid = 1'b0;
    in_data = 8'hEE;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data = b;
    for (int w = 0; w < 50; w++) begin
      @(negedge clk);
      if (in_ready) begin
        taken = 1'b1;
        break;
      end
      stallCount++;
    end
    if (!taken) begin
      nChecks++;
      $error("[TB] FAIL handshake timeout: observed in_ready=0 expected 1 within 50 clks");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    applyStimulus(w[31:24], $urandom_range(0, maxGap));
    applyStimulus(w[23:16], $urandom_range(0, maxGap));
    applyStimulus(w[15:8],  $urandom_range(0, maxGap));
    applyStimulus(w[7:0],   $urandom_range(0, maxGap));
  endtask

  task automatic checkLog(input string tag, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++)
      if (logAddr[i] !== 32'(i * 4) || logData[i] !== wordPattern(i)) bad++;
    checkOutput(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset imem_we", 32'(imem_we), 32'd0);
    checkOutput("reset imem_addr", imem_addr, 32'h0);
    checkOutput("reset imem_wdata", imem_wdata, 32'h0);
    checkOutput("reset words_loaded", 32'(words_loaded), 32'd0);
    checkOutput("reset cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("reset load_err", 32'(load_err), 32'd0);

    $display("[TB] test 1: two-word image at 1 byte/clk");
    resetDut();
    checkOutput("idle in_ready", 32'(in_ready), 32'd0);
    pulseStart();
    applyStimulus(8'h00, 0); applyStimulus(8'h02, 0);
    applyStimulus(8'h20, 0); applyStimulus(8'h08, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h05, 0);
    applyStimulus(8'h08, 0); applyStimulus(8'h00, 0);
    applyStimulus(8'h00, 0); applyStimulus(8'h00, 0);
    checkOutput("t1 last write we", 32'(imem_we), 32'd1);
    checkOutput("t1 last write addr", imem_addr, 32'h4);
    checkOutput("t1 last write data", imem_wdata, 32'h0800_0000);
    checkOutput("t1 words_loaded", 32'(words_loaded), 32'd2);
    checkOutput("t1 in_ready in last write", 32'(in_ready), 32'd0);
    checkOutput("t1 cpu_run early", 32'(cpu_run), 32'd0);
    @(posedge clk); #1;
    checkOutput("t1 cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("t1 we dropped", 32'(imem_we), 32'd0);
    checkOutput("t1 addr held", imem_addr, 32'h4);
    checkOutput("t1 no stalls", 32'(stallCount), 32'd0);
    checkOutput("t1 write count", 32'(writeCount), 32'd2);
    checkOutput("t1 first addr", logAddr[0], 32'h0);
    checkOutput("t1 first data", logData[0], 32'h2008_0005);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("async cpu_run drop", 32'(cpu_run), 32'd0);

    $display("[TB] test 2: zero-length header");
    resetDut();
    pulseStart();
    applyStimulus(8'h00, 0); applyStimulus(8'h00, 0);
    checkOutput("t2 load_err", 32'(load_err), 32'd1);
    checkOutput("t2 in_ready", 32'(in_ready), 32'd0);
    repeat (100) @(posedge clk);
    #1;
    pulseStart();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t2 load_err sticky", 32'(load_err), 32'd1);
    checkOutput("t2 cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("t2 no writes", 32'(writeCount), 32'd0);

    $display("[TB] test 3: count boundaries");
    resetDut();
    pulseStart();
    applyStimulus(8'h01, 0); applyStimulus(8'h01, 0);
    checkOutput("t3 257 rejected", 32'(load_err), 32'd1);
    resetDut();
    pulseStart();
    applyStimulus(8'h01, 0); applyStimulus(8'h00, 0);
    checkOutput("t3 256 accepted", 32'(load_err), 32'd0);
    for (int i = 0; i < 256; i++) sendWord(wordPattern(i), 0);
    @(posedge clk); #1;
    checkOutput("t3 cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("t3 write count", 32'(writeCount), 32'd256);
    checkOutput("t3 words_loaded", 32'(words_loaded), 32'd256);
    checkOutput("t3 last addr", logAddr[255], 32'h3FC);
    checkLog("t3 contents", 256);

    $display("[TB] test 4: eight words with random gaps");
    resetDut();
    pulseStart();
    applyStimulus(8'h00, 2); applyStimulus(8'h08, 3);
    for (int i = 0; i < 8; i++) sendWord(wordPattern(i), 3);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t4 write count", 32'(writeCount), 32'd8);
    checkOutput("t4 strobe width", 32'(wideCount), 32'd0);
    checkOutput("t4 cpu_run", 32'(cpu_run), 32'd1);
    checkLog("t4 contents", 8);

    $display("[TB] test 5: reset mid-word");
    resetDut();
    pulseStart();
    applyStimulus(8'h00, 0); applyStimulus(8'h04, 0);
    for (int i = 0; i < 3; i++) sendWord(wordPattern(i), 0);
    applyStimulus(8'hC0, 0); applyStimulus(8'h03, 0); applyStimulus(8'h09, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("t5 in_ready", 32'(in_ready), 32'd0);
    checkOutput("t5 addr", imem_addr, 32'h0);
    checkOutput("t5 wdata", imem_wdata, 32'h0);
    checkOutput("t5 words_loaded", 32'(words_loaded), 32'd0);
    checkOutput("t5 load_err", 32'(load_err), 32'd0);
    resetDut();
    pulseStart();
    applyStimulus(8'h00, 0); applyStimulus(8'h02, 0);
    for (int i = 0; i < 2; i++) sendWord(wordPattern(i), 1);
    @(posedge clk); #1;
    checkOutput("t5 reload count", 32'(writeCount), 32'd2);
    checkOutput("t5 reload cpu_run", 32'(cpu_run), 32'd1);
    checkLog("t5 reload contents", 2);

    $display("[TB] test 6: stray start and valid after load");
    resetDut();
    pulseStart();
    applyStimulus(8'h00, 0); applyStimulus(8'h03, 0);
    sendWord(wordPattern(0), 0);
    pulseStart();
    for (int i = 1; i < 3; i++) sendWord(wordPattern(i), 0);
    @(posedge clk); #1;
    pulseStart();
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("t6 write count", 32'(writeCount), 32'd3);
    checkOutput("t6 words_loaded", 32'(words_loaded), 32'd3);
    checkOutput("t6 cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("t6 in_ready", 32'(in_ready), 32'd0);
    checkLog("t6 contents", 3);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
